// File: rtl/dac_arb_pkg.sv
// Shared definitions for the DAC stream arbiter: parameter defaults, FSM state enum, round-robin grant search.
// Latency: none. This package holds only types, constants and a combinational function.
// Backpressure: not applicable.
package dac_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int DIV_W_DEF   = 16;

  // Upper bound on requesters the grant search can handle (5-bit index).
  localparam int MAX_REQ     = 32;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TICK = 2'd1,
    S_ARB       = 2'd2,
    S_SEND      = 2'd3
  } state_e;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } grant_t;

  // Return the first requester with valid set, searching from last+1 and wrapping
  // modulo n. Because last < n and i <= n, one subtraction replaces the modulo.
  function automatic grant_t rr_next_grant(input logic [MAX_REQ-1:0] valid,
                                           input logic [4:0]         last,
                                           input int                 n);
    grant_t g;
    int     j;
    g.found = 1'b0;
    g.idx   = '0;
    j       = 0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (i <= n && !g.found) begin
        j = int'(last) + i;
        if (j >= n) j = j - n;
        if (valid[j[4:0]]) begin
          g.found = 1'b1;
          g.idx   = j[4:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/dac_rate_tick.sv
// Sample-rate tick generator: counts 0..rate_div while en is high, pulsing tick on the last count.
// Latency: tick is combinational from the count register; one pulse every rate_div+1 cycles.
// Backpressure: none. rate_div is latched only at a wrap (or while disabled), never mid-count.
// Ports: mclk, rst (sync, active-high), en, rate_div[DIV_W] -> tick.
module dac_rate_tick
  import dac_arb_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_limit;

  assign tick = en && (r_count == r_limit);

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_count <= '0;
      r_limit <= rate_div;
    end else if (!en || tick) begin
      // Holding at 0 while disabled; a new period only takes hold at a wrap.
      r_count <= '0;
      r_limit <= rate_div;
    end else begin
      r_count <= r_count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/dac_stream_arbiter.sv
// Round-robin arbiter feeding one DAC driver from NUM_REQ AXI-stream requesters at a fixed sample rate.
// Latency: tick in cycle N -> s_axis_ready pulse in N+1 -> m_axis_valid in N+2.
// Backpressure: SEND holds m_axis_data until m_axis_ready; ticks arriving in ARB/SEND are dropped.
// Ports: mclk, rst (sync, active-high), en, rate_div; s_axis_valid/data/ready (requesters);
//        m_axis_valid/data/ready (DAC driver); grant_id, busy status.
// Option: define DAC_ARB_OVERRUN_CNT_EN to add output overrun_cnt[15:0] (saturating dropped-tick count).
module dac_stream_arbiter
  import dac_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input  logic                       mclk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DIV_W-1:0]           rate_div,
  input  logic [NUM_REQ-1:0]         s_axis_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  s_axis_data,
  output logic [NUM_REQ-1:0]         s_axis_ready,
  output logic                       m_axis_valid,
  output logic [DATA_W-1:0]          m_axis_data,
  input  logic                       m_axis_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
`ifdef DAC_ARB_OVERRUN_CNT_EN
  ,
  output logic [15:0]                overrun_cnt
`endif
);

  localparam int GID_W = $clog2(NUM_REQ);

  // The state register stays a plain vector; the enum only names the encodings.
  localparam logic [1:0] ST_IDLE      = S_IDLE;
  localparam logic [1:0] ST_WAIT_TICK = S_WAIT_TICK;
  localparam logic [1:0] ST_ARB       = S_ARB;
  localparam logic [1:0] ST_SEND      = S_SEND;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [GID_W-1:0]  r_grant_id;
  logic [GID_W-1:0]  r_last_grant;
  logic              w_tick;
  grant_t            w_pick;
  logic              w_grant;

  dac_rate_tick #(
    .DIV_W(DIV_W)
  ) u_rate_tick (
    .mclk    (mclk),
    .rst     (rst),
    .en      (en),
    .rate_div(rate_div),
    .tick    (w_tick)
  );

  assign w_pick  = rr_next_grant(MAX_REQ'(s_axis_valid), 5'(r_last_grant), NUM_REQ);

  // A grant needs en still high; dropping en in ARB abandons the slot.
  assign w_grant = (r_state == ST_ARB) && en && w_pick.found;

  assign s_axis_ready = w_grant ? (NUM_REQ'(1) << w_pick.idx) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en) w_state_nxt = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!en)         w_state_nxt = ST_IDLE;
        else if (w_tick) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (!en)               w_state_nxt = ST_IDLE;
        else if (w_pick.found) w_state_nxt = ST_SEND;
        else                   w_state_nxt = ST_WAIT_TICK;
      end
      ST_SEND: begin
        // A transfer in flight always completes, even if en has dropped.
        if (m_axis_ready) w_state_nxt = en ? ST_WAIT_TICK : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_data       <= '0;
      r_grant_id   <= '0;
      // Starting at the top index makes the first search begin at requester 0.
      r_last_grant <= GID_W'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_data       <= s_axis_data[w_pick.idx*DATA_W +: DATA_W];
        r_grant_id   <= w_pick.idx[GID_W-1:0];
        r_last_grant <= w_pick.idx[GID_W-1:0];
      end
    end
  end

  assign m_axis_valid = (r_state == ST_SEND);
  assign m_axis_data  = r_data;
  assign grant_id     = r_grant_id;
  assign busy         = (r_state != ST_IDLE);

`ifdef DAC_ARB_OVERRUN_CNT_EN
  logic [15:0] r_overrun_cnt;

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_overrun_cnt <= '0;
    end else if (w_tick && (r_state == ST_ARB || r_state == ST_SEND) &&
                 r_overrun_cnt != 16'hFFFF) begin
      r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end
  end

  assign overrun_cnt = r_overrun_cnt;
`endif

endmodule

// File: tb/tb_dac_stream_arbiter.sv
// Self-checking bench for dac_stream_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_dac_stream_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int VW = 16;

  logic              mclk = 1'b0;
  logic              rst;
  logic              en;
  logic [VW-1:0]     rate_div;
  logic [NR-1:0]     s_axis_valid;
  logic [NR*DW-1:0]  s_axis_data;
  logic [NR-1:0]     s_axis_ready;
  logic              m_axis_valid;
  logic [DW-1:0]     m_axis_data;
  logic              m_axis_ready;
  logic [1:0]        grant_id;
  logic              busy;
`ifdef DAC_ARB_OVERRUN_CNT_EN
  logic [15:0]       overrun_cnt;
`endif

  always #5 mclk = ~mclk;

  dac_stream_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .DIV_W(VW)) dut (
    .mclk        (mclk),
    .rst         (rst),
    .en          (en),
    .rate_div    (rate_div),
    .s_axis_valid(s_axis_valid),
    .s_axis_data (s_axis_data),
    .s_axis_ready(s_axis_ready),
    .m_axis_valid(m_axis_valid),
    .m_axis_data (m_axis_data),
    .m_axis_ready(m_axis_ready),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef DAC_ARB_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: sample-period position, whether the scheduler is active,
  // whether an arbitration slot is due, and whether a sample awaits the DAC.
  int          m_cnt, m_lim;
  bit          m_active, m_arb, m_pend;
  logic [15:0] m_data;
  int          m_gid, m_last, m_ovr;

  int          cyc;
  logic [15:0] q_out[$];
  int          q_gid[$];
  int          q_t[$];
  int          bad_lane, dbl_ready, mv_cnt, busy_low, rdy_cnt;
  logic [NR-1:0] prev_ready;
  logic        last_mv;
  logic [15:0] last_md;
  int          last_gid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= NR; k++) begin
      int idx = (m_last + k) % NR;
      if (s_axis_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_lim = int'(rate_div);
    m_active = 0; m_arb = 0; m_pend = 0;
    m_data = '0; m_gid = 0; m_last = NR - 1; m_ovr = 0;
  endtask

  task automatic model_update();
    bit tick;
    int p;
    tick = en && (m_cnt == m_lim);
    p = model_pick();
    if (rst) begin
      model_reset();
      return;
    end
    if (!en || tick) begin
      m_cnt = 0;
      m_lim = int'(rate_div);
    end else begin
      m_cnt++;
    end
    if (tick && (m_arb || m_pend) && m_ovr < 65535) m_ovr++;
    if (!m_active) begin
      m_active = en;
    end else if (m_pend) begin
      if (m_axis_ready) begin
        m_pend = 0;
        if (!en) m_active = 0;
      end
    end else if (m_arb) begin
      m_arb = 0;
      if (!en) m_active = 0;
      else if (p >= 0) begin
        m_pend = 1;
        m_data = s_axis_data[p*DW +: DW];
        m_gid  = p;
        m_last = p;
      end
    end else begin
      if (!en) m_active = 0;
      else if (tick) m_arb = 1;
    end
  endtask

  task automatic compare();
    int p = model_pick();
    logic [NR-1:0] er = '0;
    if (m_arb && en && p >= 0) er[p] = 1'b1;
    chk("s_axis_ready", 32'(s_axis_ready), 32'(er));
    chk("m_axis_valid", 32'(m_axis_valid), 32'(m_pend));
    chk("m_axis_data",  32'(m_axis_data),  32'(m_data));
    chk("grant_id",     32'(grant_id),     32'(m_gid));
    chk("busy",         32'(busy),         32'(m_active));
`ifdef DAC_ARB_OVERRUN_CNT_EN
    chk("overrun_cnt",  32'(overrun_cnt),  32'(m_ovr));
`endif
  endtask

  // One clock cycle: inputs already driven; compare mid-cycle, then advance model at the edge.
  task automatic step();
    #2;
    compare();
    last_mv  = m_axis_valid;
    last_md  = m_axis_data;
    last_gid = int'(grant_id);
    if (!rst) begin
      if (m_axis_valid && m_axis_ready) begin
        q_out.push_back(m_axis_data);
        q_gid.push_back(int'(grant_id));
        q_t.push_back(cyc);
      end
      if ((s_axis_ready & 4'b0101) != 0) bad_lane++;
      if ((s_axis_ready & prev_ready) != 0) dbl_ready++;
      if (s_axis_ready != 0) rdy_cnt++;
      if (m_axis_valid) mv_cnt++;
      if (!busy) busy_low++;
    end
    prev_ready = s_axis_ready;
    @(posedge mclk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic clear_stats();
    q_out.delete(); q_gid.delete(); q_t.delete();
    bad_lane = 0; dbl_ready = 0; mv_cnt = 0; busy_low = 0; rdy_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge mclk);
    #1;
    model_reset();
    #2;
    chk("rst_ready", 32'(s_axis_ready), 32'd0);
    chk("rst_mvalid", 32'(m_axis_valid), 32'd0);
    chk("rst_mdata", 32'(m_axis_data), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    clear_stats();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp2 [5];
    int budget;
    int stall;
    cyc = 0;
    prev_ready = '0;
    rst = 1'b1; en = 1'b1; rate_div = 16'd49;
    s_axis_valid = 4'b0001; s_axis_data = {16'h0, 16'h0, 16'h0, 16'hCAFE};
    m_axis_ready = 1'b1;
    clear_stats();

    // Single requester, period 50.
    do_reset();
    repeat (170) step();
    chk("t1_count", 32'(q_out.size()), 32'd3);
    if (q_out.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_data", 32'(q_out[i]), 32'hCAFE);
        chk("t1_gid", 32'(q_gid[i]), 32'd0);
      end
      chk("t1_period_a", 32'(q_t[1] - q_t[0]), 32'd50);
      chk("t1_period_b", 32'(q_t[2] - q_t[1]), 32'd50);
    end

    // All requesters valid: strict rotation.
    rate_div = 16'd3; s_axis_valid = 4'b1111;
    s_axis_data = {16'hC0DE, 16'hFACE, 16'hBEEF, 16'hCAFE};
    do_reset();
    repeat (30) step();
    exp2 = '{16'hCAFE, 16'hBEEF, 16'hFACE, 16'hC0DE, 16'hCAFE};
    chk("t2_count_ge5", 32'(q_out.size() >= 5), 32'd1);
    if (q_out.size() >= 5)
      for (int i = 0; i < 5; i++) chk("t2_order", 32'(q_out[i]), 32'(exp2[i]));
    chk("t2_ready_pulse", 32'(dbl_ready), 32'd0);

    // Only requesters 1 and 3 valid.
    s_axis_valid = 4'b1010;
    do_reset();
    repeat (30) step();
    chk("t3_count_ge4", 32'(q_gid.size() >= 4), 32'd1);
    if (q_gid.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t3_grant", 32'(q_gid[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
    chk("t3_idle_lanes", 32'(bad_lane), 32'd0);

    // No requester valid: slots skipped, scheduler stays active.
    s_axis_valid = 4'b0000;
    do_reset();
    step();
    clear_stats();
    repeat (16) step();
    chk("t4_mvalid", 32'(mv_cnt), 32'd0);
    chk("t4_ready", 32'(rdy_cnt), 32'd0);
    chk("t4_busy_low", 32'(busy_low), 32'd0);

    // Stalled DAC: data held, overruns counted.
    s_axis_valid = 4'b0001; s_axis_data = {16'h0, 16'h0, 16'h0, 16'h1234};
    m_axis_ready = 1'b0;
    do_reset();
    budget = 0;
    do begin step(); budget++; end while (!last_mv && budget < 20);
    chk("t5_reach_send", 32'(last_mv), 32'd1);
    stall = 0;
    repeat (19) begin
      step();
      if (!last_mv || last_md !== 16'h1234) stall++;
    end
    chk("t5_stable", 32'(stall), 32'd0);
`ifdef DAC_ARB_OVERRUN_CNT_EN
    #2;
    chk("t5_overrun", 32'(overrun_cnt), 32'd5);
`endif
    m_axis_ready = 1'b1;
    repeat (4) step();

    // Reset in SEND aborts the sample; next grant restarts at requester 0.
    s_axis_valid = 4'b1111;
    s_axis_data = {16'hC0DE, 16'hFACE, 16'hBEEF, 16'hCAFE};
    do_reset();
    budget = 0;
    while (q_out.size() < 1 && budget < 20) begin step(); budget++; end
    m_axis_ready = 1'b0;
    budget = 0;
    do begin step(); budget++; end while (!last_mv && budget < 20);
    chk("t6_send_gid", 32'(last_gid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    chk("t6_ready", 32'(s_axis_ready), 32'd0);
    chk("t6_mvalid", 32'(m_axis_valid), 32'd0);
    chk("t6_mdata", 32'(m_axis_data), 32'd0);
    chk("t6_gid", 32'(grant_id), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    m_axis_ready = 1'b1;
    clear_stats();
    budget = 0;
    while (q_out.size() < 1 && budget < 20) begin step(); budget++; end
    chk("t6_first_after", 32'(q_out.size()), 32'd1);
    if (q_out.size() >= 1) begin
      chk("t6_first_gid", 32'(q_gid[0]), 32'd0);
      chk("t6_first_data", 32'(q_out[0]), 32'hCAFE);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      s_axis_valid = 4'($urandom);
      s_axis_data  = {$urandom, $urandom};
      m_axis_ready = ($urandom_range(0, 9) < 7);
      en           = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 199) == 0) rate_div = 16'($urandom_range(0, 6));
      rst          = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_stream_arbiter.md
DAC_STREAM_ARBITER -- requirements
Module: dac_stream_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of upstream AXI-stream requesters sharing one DAC driver.
REQ-002 Parameter DATA_W, default 16: sample width, matching the DAC driver s_axis_data.
REQ-003 Parameter DIV_W, default 16: width of the sample-rate divider.
REQ-004 mclk  in  1  system clock; all logic SHALL be on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  scheduler enable.
REQ-007 rate_div  in  DIV_W  sample period minus one, in mclk cycles.
REQ-008 s_axis_valid  in  NUM_REQ  per-requester valid.
REQ-009 s_axis_data  in  NUM_REQ*DATA_W  packed samples; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-010 s_axis_ready  out  NUM_REQ  per-requester ready, one-hot or zero.
REQ-011 m_axis_valid  out  1  sample valid toward the DAC driver.
REQ-012 m_axis_data  out  DATA_W  sample toward the DAC driver.
REQ-013 m_axis_ready  in  1  DAC driver ready.
REQ-014 grant_id  out  $clog2(NUM_REQ)  index of the requester owning the current/last sample.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT_TICK, ARB and SEND.
REQ-017 Tick counter: while en=1 it SHALL count 0..rate_div, asserting an internal tick on the cycle where count==rate_div and wrapping to 0; rate_div=0 SHALL tick every cycle.
REQ-018 IDLE->WAIT_TICK when en=1; counter SHALL be held at 0 while en=0.
REQ-019 WAIT_TICK->ARB on tick.
REQ-020 ARB: grant SHALL go to the first requester with valid=1, searching round-robin from last_grant+1 modulo NUM_REQ.
REQ-021 ARB: s_axis_ready SHALL be high only for the granted index, for exactly this one cycle; data SHALL be captured into a holding register and last_grant/grant_id updated; next state SEND.
REQ-022 ARB with no valid requester: s_axis_ready SHALL stay 0, the slot SHALL be skipped, and the next state SHALL be WAIT_TICK.
REQ-023 SEND: m_axis_valid=1 with m_axis_data stable until the cycle m_axis_ready=1; then next state WAIT_TICK, or IDLE if en=0.
REQ-024 Latency: a tick in cycle N SHALL give m_axis_valid=1 in cycle N+2.
REQ-025 A tick arriving in SEND or ARB is an overrun: it SHALL be dropped, with no queueing.
REQ-026 en dropping in WAIT_TICK or ARB SHALL return the FSM to IDLE next cycle without a grant; in SEND the transfer SHALL complete first.
REQ-027 rate_div changes SHALL take effect at the next wrap; rate_div is not sampled mid-count.

Reset
REQ-028 On rst the FSM SHALL enter IDLE, and the counter, s_axis_ready, m_axis_valid, m_axis_data, grant_id and busy SHALL all be 0.
REQ-029 On rst last_grant SHALL be NUM_REQ-1, so the first grant searches from requester 0.
REQ-030 rst mid-SEND SHALL abort the sample; the sample SHALL NOT be replayed.

Configuration
REQ-031 With DAC_ARB_OVERRUN_CNT_EN defined, output overrun_cnt [15:0] SHALL increment on each REQ-025 overrun, saturate at 16'hFFFF and clear on rst.
REQ-032 Without DAC_ARB_OVERRUN_CNT_EN, the port and its logic SHALL be absent and overruns silently dropped.

Structure
REQ-033 Package dac_arb_pkg SHALL hold the FSM state enum, the NUM_REQ/DATA_W/DIV_W defaults and the round-robin next-grant function.
REQ-034 Sub-module dac_rate_tick SHALL implement the tick counter (mclk, rst, en, rate_div -> tick).

Verification
REQ-035 Test 1: rate_div=49, requester 0 only, valid, data 16'hCAFE, m_axis_ready=1 -> one m_axis_data=16'hCAFE every 50 cycles, grant_id=0.
REQ-036 Test 2: all 4 requesters valid, data 16'hCAFE/BEEF/FACE/C0DE -> outputs in order CAFE, BEEF, FACE, C0DE, CAFE, and each s_axis_ready is a single-cycle pulse.
REQ-037 Test 3: only requesters 1 and 3 valid -> grants alternate 1,3,1,3; no s_axis_ready ever on 0 or 2.
REQ-038 Test 4: no requester valid for 3 ticks -> m_axis_valid stays 0 and the FSM returns to WAIT_TICK each time.
REQ-039 Test 5: rate_div=3, m_axis_ready held 0 for 20 cycles -> m_axis_valid and data stay stable; with the macro defined, overrun_cnt reaches 5.
REQ-040 Test 6: rst asserted during SEND -> all outputs 0 next cycle; after release, the first grant goes to requester 0.
